// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch stage.
package fetch_pkg;

  localparam int PC_W   = 12;
  localparam int INST_W = 19;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: small synchronous FIFO of PC/instruction pairs.
// Flush clears count and both pointers; entries are left stale.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC register, fetch queue and
// redirect handling feeding decode over valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W   = fetch_pkg::PC_W,
  parameter int INST_W = fetch_pkg::INST_W,
  parameter int DEPTH  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic [CW-1:0]     occupancy
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PC_W-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  fetch_entry_t    entry;
  fetch_entry_t    head;

  assign imem_pc   = fetch_pc;
  assign occupancy = count;
  assign entry     = '{pc: fetch_pc, inst: imem_inst};

  assign id_valid = (count != '0) && !redirect_valid;
  assign pop      = id_valid && id_ready;
  assign push     = !redirect_valid && ((count != FULL) || pop);

  assign id_inst = id_valid ? head.inst : '0;
  assign id_pc   = id_valid ? head.pc   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_pc <= RESET_PC;
    else if (redirect_valid)
      fetch_pc <= redirect_pc;
    else if (push)
      fetch_pc <= fetch_pc + PC_W'(1);
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (entry),
    .head  (head),
    .count (count)
  );

endmodule
